// File: rtl/lcd_seq_if.sv
// Character handshake from upstream plus the command/data drive toward lcd_ctrl.
interface lcd_seq_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       clear_req;
  logic       char_ready;
  logic       init_done;
  logic       rs_out;
  logic       rw_out;
  logic [7:0] data_out;
  logic       start_out;

  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, init_done, rs_out, rw_out, data_out, start_out
  );

  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, init_done, rs_out, rw_out, data_out, start_out
  );
endinterface

// File: rtl/lcd_seq.sv
// HD44780 4-bit init and character sequencer feeding lcd_ctrl; every transfer is
// paced by a fixed wait because lcd_ctrl reports no completion.
module lcd_seq #(
  parameter int unsigned PWR_WAIT = 150000,
  parameter int unsigned CMD_WAIT = 500,
  parameter int unsigned CLR_WAIT = 16000,
  parameter int unsigned COLS     = 16
) (
  input  logic     clk,
  input  logic     rst,
  lcd_seq_if.slave bus
);
  localparam int unsigned MAX_AB   = (PWR_WAIT > CMD_WAIT) ? PWR_WAIT : CMD_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_AB > CLR_WAIT) ? MAX_AB : CLR_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned COL_W    = $clog2(COLS + 1);
  localparam int unsigned ROM_N    = 6;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] ADDR_L0   = 8'h80;
  localparam logic [7:0] ADDR_L1   = 8'hC0;
  localparam logic [7:0] NEWLINE   = 8'h0A;

  typedef enum logic [2:0] {
    PWR, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT, ADDR_ISSUE, ADDR_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rom_idx;
  logic             line;
  logic [COL_W-1:0] col;
  logic             addr_pend;
  logic [7:0]       addr_cmd;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Only a clear command needs the long hold; a data byte of 0x01 is ordinary.
  function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] d);
    return (!rs && d == CMD_CLEAR) ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PWR;
      cnt            <= '0;
      rom_idx        <= '0;
      line           <= 1'b0;
      col            <= '0;
      addr_pend      <= 1'b0;
      addr_cmd       <= 8'h00;
      bus.char_ready <= 1'b0;
      bus.init_done  <= 1'b0;
      bus.rs_out     <= 1'b0;
      bus.rw_out     <= 1'b0;
      bus.data_out   <= 8'h00;
      bus.start_out  <= 1'b0;
    end else begin
      bus.start_out <= 1'b0;
      bus.rw_out    <= 1'b0;
      case (state)
        PWR: begin
          if (cnt == CNT_W'(PWR_WAIT)) begin
            bus.start_out <= 1'b1;
            bus.rs_out    <= 1'b0;
            bus.data_out  <= init_rom(3'd0);
            rom_idx       <= 3'd0;
            state         <= INIT_ISSUE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        INIT_ISSUE: begin
          cnt   <= wait_load(bus.rs_out, bus.data_out);
          state <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rom_idx == 3'(ROM_N - 1)) begin
            bus.init_done  <= 1'b1;
            bus.char_ready <= 1'b1;
            state          <= IDLE;
          end else begin
            rom_idx       <= rom_idx + 3'd1;
            bus.start_out <= 1'b1;
            bus.data_out  <= init_rom(rom_idx + 3'd1);
            state         <= INIT_ISSUE;
          end
        end
        IDLE: begin
          if (bus.char_valid && bus.char_ready) begin
            bus.char_ready <= 1'b0;
            bus.start_out  <= 1'b1;
            addr_pend      <= 1'b0;
            state          <= ISSUE;
            if (bus.clear_req) begin
              bus.rs_out   <= 1'b0;
              bus.data_out <= CMD_CLEAR;
              line         <= 1'b0;
              col          <= '0;
            end else if (bus.char_data == NEWLINE) begin
              bus.rs_out   <= 1'b0;
              bus.data_out <= line ? ADDR_L0 : ADDR_L1;
              line         <= ~line;
              col          <= '0;
            end else begin
              bus.rs_out   <= 1'b1;
              bus.data_out <= bus.char_data;
              // Last column: queue the line-change address behind this write.
              if (col == COL_W'(COLS - 1)) begin
                addr_pend <= 1'b1;
                addr_cmd  <= line ? ADDR_L0 : ADDR_L1;
                line      <= ~line;
                col       <= '0;
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        ISSUE: begin
          cnt   <= wait_load(bus.rs_out, bus.data_out);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (addr_pend) begin
            addr_pend     <= 1'b0;
            bus.start_out <= 1'b1;
            bus.rs_out    <= 1'b0;
            bus.data_out  <= addr_cmd;
            state         <= ADDR_ISSUE;
          end else begin
            bus.char_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        ADDR_ISSUE: begin
          cnt   <= CNT_W'(CMD_WAIT - 1);
          state <= ADDR_WAIT;
        end
        ADDR_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            bus.char_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= PWR;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_seq.sv
// Scoreboard bench for lcd_seq: expected lcd_ctrl transfers are queued as stimulus
// is driven and matched against each start_out pulse.
module tb_lcd_seq;
  localparam int PWR_W = 20;
  localparam int CMD_W = 4;
  localparam int CLR_W = 10;
  localparam int NCOLS = 16;
  localparam int LIMIT = 2000;
  localparam int INIT_DONE_CYC = (PWR_W + 1) + 4 * (CMD_W + 1) + (CLR_W + 1) + (CMD_W + 1);

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_pulse = 0;
  logic prev_start = 1'b0;
  exp_t sb[$];
  logic m_line = 1'b0;
  int   m_col = 0;

  lcd_seq_if bus ();

  lcd_seq #(
    .PWR_WAIT(PWR_W),
    .CMD_WAIT(CMD_W),
    .CLR_WAIT(CLR_W),
    .COLS(NCOLS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every start_out pulse must match the oldest queued transfer.
  always @(negedge clk) begin
    exp_t e;
    prev_start <= bus.start_out;
    if (rst) begin
      last_pulse <= 0;
    end else if (bus.start_out) begin
      check_eq("pulse_expected", 32'(sb.size() > 0), 1);
      check_eq("back_to_back", prev_start, 1'b0);
      check_eq("rw_out", bus.rw_out, 1'b0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("rs_out", bus.rs_out, e.rs);
        check_eq("data_out", bus.data_out, e.data);
        if (e.gap > 0) check_eq("pulse_gap", cyc - last_pulse, e.gap);
      end
      last_pulse <= cyc;
    end
  end

  task automatic push(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h33, PWR_W + 1);
    push(1'b0, 8'h32, CMD_W + 1);
    push(1'b0, 8'h28, CMD_W + 1);
    push(1'b0, 8'h0C, CMD_W + 1);
    push(1'b0, 8'h01, CMD_W + 1);
    push(1'b0, 8'h06, CLR_W + 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.char_valid = 1'b0;
    bus.clear_req  = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_char_ready", bus.char_ready, 1'b0);
    check_eq("rst_init_done", bus.init_done, 1'b0);
    check_eq("rst_rs_out", bus.rs_out, 1'b0);
    check_eq("rst_rw_out", bus.rw_out, 1'b0);
    check_eq("rst_data_out", bus.data_out, 8'h00);
    check_eq("rst_start_out", bus.start_out, 1'b0);
    sb.delete();
    push_init();
    m_line = 1'b0;
    m_col  = 0;
    rst = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("init_timeout", 32'(n < LIMIT), 1);
    check_eq("init_cycle", cyc, INIT_DONE_CYC);
    check_eq("init_ready", bus.char_ready, 1'b1);
    check_eq("init_queue_empty", sb.size(), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.char_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_timeout", 32'(n < LIMIT), 1);
  endtask

  // Queue the transfers the request should produce, hand it over, time the recovery.
  task automatic send(input logic clr, input logic [7:0] d);
    int n = 0;
    int lat;
    wait_ready();
    if (clr) begin
      push(1'b0, 8'h01, 0);
      lat = CLR_W + 1;
      m_line = 1'b0;
      m_col  = 0;
    end else if (d == 8'h0A) begin
      push(1'b0, m_line ? 8'h80 : 8'hC0, 0);
      lat = CMD_W + 1;
      m_line = ~m_line;
      m_col  = 0;
    end else begin
      push(1'b1, d, 0);
      lat = CMD_W + 1;
      m_col++;
      if (m_col == NCOLS) begin
        push(1'b0, m_line ? 8'h80 : 8'hC0, CMD_W + 1);
        lat += CMD_W + 1;
        m_line = ~m_line;
        m_col  = 0;
      end
    end
    bus.char_valid = 1'b1;
    bus.clear_req  = clr;
    bus.char_data  = d;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    bus.clear_req  = 1'b0;
    check_eq("start_latency", bus.start_out, 1'b1);
    check_eq("ready_drop", bus.char_ready, 1'b0);
    while (!bus.char_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_latency", n, lat);
  endtask

  initial begin
    int n;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.clear_req  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    wait_init();

    send(1'b0, 8'h41);
    for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h42 + i));
    for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h61 + i));

    // Land on line 0 column 0 before exercising newline.
    send(1'b1, 8'h00);
    send(1'b0, 8'h0A);
    for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h30 + i));

    send(1'b1, 8'h41);
    for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h50 + i));

    // Reset during a data wait.
    wait_ready();
    push(1'b1, 8'h5A, 0);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h5A;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    check_eq("mid_data_start", bus.start_out, 1'b1);
    do_reset();
    wait_init();

    // Reset during the init clear wait.
    n = 0;
    do_reset();
    while (cyc < PWR_W + 4 * (CMD_W + 1) + 4 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("mid_init_timeout", 32'(n < LIMIT), 1);
    do_reset();
    wait_init();

    send(1'b0, 8'h21);
    repeat (10) @(posedge clk);
    #1;
    check_eq("final_queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
